cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Arbiter for the shared 40-bit common data bus ({tag[39:32], value[31:0]}) driven by the adder, multiplier and load units.
- Each unit presents a result for a single cycle; the arbiter captures it in a per-source FIFO.
- It broadcasts at most one result per cycle using round-robin priority.
- The registered CDB output feeds every reservation station's tag-match logic.

Parameters:
- FIFO_DEPTH, 2, entries per source FIFO (power of 2, at least 2).
- DATA_W, 40, bus width ({tag, value}).
- TAG_W, 8, tag field width (upper bits of the bus).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- add_valid  input  1  adder result present this cycle.
- add_data  input  40  adder result {tag, value}.
- add_ready  output  1  adder FIFO not full.
- mult_valid  input  1  multiplier result present.
- mult_data  input  40  multiplier result.
- mult_ready  output  1  multiplier FIFO not full.
- load_valid  input  1  load result present.
- load_data  input  40  load result.
- load_ready  output  1  load FIFO not full.
- cdb_valid  output  1  broadcast valid this cycle.
- cdb_bus  output  40  broadcast {tag, value}.
- cdb_src  output  2  winner: 0 = add, 1 = mult, 2 = load.
- overflow  output  3  sticky drop flags: [0] add, [1] mult, [2] load.

Behaviour:
- Reset, synchronous:
  - All FIFOs empty; round-robin pointer = add.
  - Outputs: cdb_valid=0, cdb_bus=0 (see Optional Feature), cdb_src=0, overflow=3'b000.
  - *_ready=1 in the cycle after reset.
  - *_valid inputs are ignored while rst=1.
  - Reset mid-operation discards all queued results.
- Ready:
  - x_ready = (count_x < FIFO_DEPTH), using the registered count at cycle start.
  - It is not relieved by a same-cycle pop.
- Enqueue:
  - At posedge, x_valid=1 with count < FIFO_DEPTH pushes x_data.
  - x_valid=1 with a full FIFO drops the data and sets overflow[x]; the flag stays set until rst.
  - x_valid=1 with tag field 8'h00 is ignored. Tag 0 is reserved as "no producer". It is not pushed and does not set overflow.
- Arbitration, each posedge:
  - Candidates are FIFOs non-empty at cycle start; a push in the same edge is not visible.
  - Search starts at the rr pointer, in order add -> mult -> load, wrapping.
  - The first non-empty FIFO wins and its head is popped.
  - rr pointer <= (winner+1) mod 3.
  - If there are no candidates, the pointer is unchanged.
- Output register:
  - With a winner: cdb_valid<=1, cdb_bus<=head, cdb_src<=winner.
  - Without a winner: cdb_valid<=0, cdb_bus<=0, cdb_src holds its value.
  - Each result is broadcast for exactly one cycle.
- Latency and throughput:
  - Result sampled at edge k, no contention: cdb_valid=1 after edge k+1 (2-edge latency).
  - Throughput is 1 broadcast/cycle.
- Simultaneous push and pop on the same FIFO: both occur, count unchanged. The pushed entry lands behind the existing entries (FIFO order preserved).
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

Optional Feature:
- Macro CDB_IDLE_HIZ_EN.
- Defined: cdb_bus is driven 40'hz whenever cdb_valid=0, so other drivers may share the wire.
- Undefined: cdb_bus is driven 40'h0 when idle.
- In both cases consumers must qualify matches with cdb_valid.

Test Plan:
- Reset, then add_valid for 1 cycle with add_data=40'h20_00000007 -> after the next edge cdb_valid=1, cdb_bus=40'h20_00000007, cdb_src=0 for exactly 1 cycle.
- Same cycle: add 40'h21_00000005, mult 40'h30_00000006, load 40'h40_00000008 -> broadcasts on 3 consecutive cycles in order add, mult, load (src 0, 1, 2); cdb_valid then drops.
- All three valid for 3 consecutive edges (FIFO_DEPTH=2) -> at the 3rd edge mult_ready=load_ready=0, those pushes are dropped, overflow=3'b110, add_ready stays 1; all queued entries drain in round-robin order.
- add_valid with tag 8'h00 -> nothing queued, cdb_valid stays 0, overflow=0.
- Queue 2 mult results, assert rst for 1 cycle before they drain -> cdb_valid=0 the next cycle, no further broadcasts, all ready=1, overflow cleared.
- With CDB_IDLE_HIZ_EN defined, idle cycles show cdb_bus=40'hz; without it, 40'h0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the shared common data bus.
// The adder, multiplier and load units each hand over a {tag, value}
// result for one cycle. Each result is held in a small per-source FIFO.
// At most one result per cycle is broadcast on a registered bus that
// feeds every reservation station's tag-match logic.
//
// Optional feature macro: CDB_IDLE_HIZ_EN
//    defined   - cdb_bus floats (all z) whenever cdb_valid is low, so the
//                wire can be shared with other drivers
//    undefined - cdb_bus reads as all zeros when idle
// In both builds, consumers must qualify tag matches with cdb_valid.

module cdb_arbiter #(
   parameter int FIFO_DEPTH = 2,
   parameter int DATA_W     = 40,
   parameter int TAG_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              add_valid,
   input  logic [DATA_W-1:0] add_data,
   output logic              add_ready,
   input  logic              mult_valid,
   input  logic [DATA_W-1:0] mult_data,
   output logic              mult_ready,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              cdb_valid,
   output logic [DATA_W-1:0] cdb_bus,
   output logic [1:0]        cdb_src,
   output logic [2:0]        overflow
);

   localparam int NSRC  = 3;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   // Source index 0 = add, 1 = mult, 2 = load.
   logic [NSRC-1:0]              inValid;
   logic [NSRC-1:0][DATA_W-1:0]  inData;

   logic [NSRC-1:0][FIFO_DEPTH-1:0][DATA_W-1:0] mem_q;
   logic [NSRC-1:0][PTR_W-1:0]  wrPtr_q;
   logic [NSRC-1:0][PTR_W-1:0]  rdPtr_q;
   logic [NSRC-1:0][CNT_W-1:0]  count_q;

   logic [NSRC-1:0] notFull;
   logic [NSRC-1:0] notEmpty;
   logic [NSRC-1:0] tagOk;
   logic [NSRC-1:0] push;
   logic [NSRC-1:0] drop;
   logic [NSRC-1:0] pop;

   logic [1:0]        rrPtr_q;
   logic [1:0]        rrPtr_d;
   logic              winValid;
   logic [1:0]        winSrc;
   logic [DATA_W-1:0] headData;

   logic              cdbValid_q;
   logic [DATA_W-1:0] cdbBus_q;
   logic [1:0]        cdbSrc_q;
   logic [2:0]        overflow_q;

   assign inValid = {load_valid, mult_valid, add_valid};
   assign inData  = {load_data, mult_data, add_data};

   // Per-source status from the registered counts at cycle start. A pop in
   // the same cycle deliberately does not relieve ready. Tag 0 means "no
   // producer", so such results are neither queued nor counted as drops.
   always_comb begin
      notFull  = '0;
      notEmpty = '0;
      tagOk    = '0;
      push     = '0;
      drop     = '0;
      for (int s = 0; s < NSRC; s++) begin
         notFull[s]  = (count_q[s] < CNT_W'(FIFO_DEPTH));
         notEmpty[s] = (count_q[s] != '0);
         tagOk[s]    = (inData[s][DATA_W-1 -: TAG_W] != '0);
         push[s]     = inValid[s] && tagOk[s] && notFull[s];
         drop[s]     = inValid[s] && tagOk[s] && !notFull[s];
      end
   end

   // Round-robin search starting at the pointer, wrapping add -> mult ->
   // load. Only FIFOs that were non-empty at cycle start are candidates;
   // the pointer moves past the winner, or stays put when nobody wins.
   always_comb begin : arbSel
      logic [2:0] cand;
      winValid = 1'b0;
      winSrc   = rrPtr_q;
      cand     = '0;
      for (int i = 0; i < NSRC; i++) begin
         cand = {1'b0, rrPtr_q} + 3'(i);
         if (cand >= 3'(NSRC)) begin
            cand = cand - 3'(NSRC);
         end
         if (!winValid && notEmpty[cand[1:0]]) begin
            winValid = 1'b1;
            winSrc   = cand[1:0];
         end
      end
      pop = '0;
      for (int s = 0; s < NSRC; s++) begin
         pop[s] = winValid && (winSrc == 2'(s));
      end
      if (winValid) begin
         rrPtr_d = (winSrc == 2'd2) ? 2'd0 : winSrc + 2'd1;
      end else begin
         rrPtr_d = rrPtr_q;
      end
   end

   // Head entry of the winning FIFO, selected without out-of-range indexing.
   always_comb begin
      headData = '0;
      for (int s = 0; s < NSRC; s++) begin
         if (winSrc == 2'(s)) begin
            headData = mem_q[s][rdPtr_q[s]];
         end
      end
   end

   // FIFO storage and pointers. Push and pop can happen together; the new
   // entry goes behind existing ones and the count stays the same. Pointers
   // wrap naturally because the depth is a power of two. Storage itself is
   // not cleared on reset since the count alone says what is valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         for (int s = 0; s < NSRC; s++) begin
            if (push[s]) begin
               mem_q[s][wrPtr_q[s]] <= inData[s];
               wrPtr_q[s]           <= wrPtr_q[s] + PTR_W'(1);
            end
            if (pop[s]) begin
               rdPtr_q[s] <= rdPtr_q[s] + PTR_W'(1);
            end
            case ({push[s], pop[s]})
               2'b10:   count_q[s] <= count_q[s] + CNT_W'(1);
               2'b01:   count_q[s] <= count_q[s] - CNT_W'(1);
               default: count_q[s] <= count_q[s];
            endcase
         end
      end
   end

   // Round-robin pointer; after reset the adder gets first look.
   always_ff @(posedge clk) begin
      if (rst) begin
         rrPtr_q <= 2'd0;
      end else begin
         rrPtr_q <= rrPtr_d;
      end
   end

   // Registered broadcast. Each popped result is shown for exactly one
   // cycle; when idle the bus register is zeroed but the source is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         cdbValid_q <= 1'b0;
         cdbBus_q   <= '0;
         cdbSrc_q   <= 2'd0;
      end else if (winValid) begin
         cdbValid_q <= 1'b1;
         cdbBus_q   <= headData;
         cdbSrc_q   <= winSrc;
      end else begin
         cdbValid_q <= 1'b0;
         cdbBus_q   <= '0;
      end
   end

   // Sticky drop flags: a result that arrives at a full FIFO is lost and the
   // flag for that source stays set until the next reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 3'b000;
      end else begin
         overflow_q <= overflow_q | drop;
      end
   end

   assign add_ready  = notFull[0];
   assign mult_ready = notFull[1];
   assign load_ready = notFull[2];
   assign cdb_valid  = cdbValid_q;
   assign cdb_src    = cdbSrc_q;
   assign overflow   = overflow_q;

`ifdef CDB_IDLE_HIZ_EN
   assign cdb_bus = cdbValid_q ? cdbBus_q : {DATA_W{1'bz}};
`else
   assign cdb_bus = cdbBus_q;
`endif

endmodule
